// File: rtl/shift_issue_stage.sv
// Issue/buffer stage in front of a combinational left barrel shifter.
// Queues (data, amount) commands, presents the head to the shifter and registers the result.
module shift_issue_stage #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_data,
    input  logic [$clog2(N)-1:0]       in_amt,
    output logic [N-1:0]               sh_data,
    output logic [$clog2(N)-1:0]       sh_amt,
    input  logic [N-1:0]               sh_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_data,
    output logic [$clog2(N)-1:0]       out_amt,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]  fifo_data [DEPTH];
    logic [AW-1:0] fifo_amt  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          not_empty;
    logic          push;
    logic          pop;

    always_comb begin
        not_empty  = (count != '0);
        push       = in_valid && in_ready;
        pop        = not_empty && (!out_valid || out_ready);
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // Empty FIFO presents zeros so the shifter never sees stale or unknown storage.
    always_comb begin
        sh_data = '0;
        sh_amt  = '0;
        if (not_empty) begin
            sh_data = fifo_data[rd_ptr];
            sh_amt  = fifo_amt[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= in_data;
            fifo_amt[wr_ptr]  <= in_amt;
        end
    end

    // in_ready is registered from the next occupancy, so it never depends on same-cycle pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            in_ready <= (count_next < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= sh_result;
            out_amt   <= sh_amt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
